pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_pkg.sv | 35 +++
 rtl/pc_fetch_unit_pc_next_sel.sv | 51 +++++
 rtl/pc_fetch_unit.sv | 190 +++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_pkg
// Description : Shared definitions for the instruction fetch unit: FSM state
//               encoding, default halt opcode, instruction field positions,
//               the bubble (NOP) word and a halt-opcode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_unit_pkg;

  // Fetch FSM encoding.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [5:0]  HALT_OPCODE_DEFAULT = 6'b111111;

  // Instruction field positions (MIPS-style encoding).
  localparam int          OPCODE_MSB = 31;
  localparam int          OPCODE_LSB = 26;
  localparam int          JIDX_MSB   = 25;
  localparam int          IMM_MSB    = 15;

  // Word loaded into IF/ID when it is emptied.
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

  function automatic logic is_halt_op(input logic [31:0] instr,
                                      input logic [5:0]  halt_op);
    return instr[OPCODE_MSB:OPCODE_LSB] == halt_op;
  endfunction

endpackage : pc_fetch_unit_pkg
`default_nettype wire

// File: rtl/pc_fetch_unit_pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_sel
// Description : Combinational redirect decision and target selection for the
//               instruction held in IF/ID.
//   i_instr_idx   [25:0] low instruction bits (jump index / branch immediate)
//   i_instr_pc4   [31:0] address of the IF/ID instruction plus 4
//   i_instr_valid        IF/ID holds a real instruction
//   i_branch, i_zero, i_jump, i_jump_reg   control for that instruction
//   i_reg_data    [31:0] jr target register value
//   o_redirect           control transfer requested
//   o_target      [31:0] selected target (jr > j > branch), unmasked
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sel
  import pc_fetch_unit_pkg::*;
(
  input  logic [25:0] i_instr_idx,
  input  logic [31:0] i_instr_pc4,
  input  logic        i_instr_valid,
  input  logic        i_branch,
  input  logic        i_zero,
  input  logic        i_jump,
  input  logic        i_jump_reg,
  input  logic [31:0] i_reg_data,
  output logic        o_redirect,
  output logic [31:0] o_target
);

  logic [31:0] w_branch_off;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_jump_tgt;

  // Sign-extended word offset, scaled to bytes; the add wraps modulo 2^32.
  assign w_branch_off = {{14{i_instr_idx[IMM_MSB]}}, i_instr_idx[IMM_MSB:0], 2'b00};
  assign w_branch_tgt = i_instr_pc4 + w_branch_off;
  assign w_jump_tgt   = {i_instr_pc4[31:28], i_instr_idx[JIDX_MSB:0], 2'b00};

  assign o_redirect = i_instr_valid & ((i_branch & i_zero) | i_jump | i_jump_reg);

  always_comb begin
    o_target = w_branch_tgt;
    if (i_jump_reg) begin
      o_target = i_reg_data;
    end else if (i_jump) begin
      o_target = w_jump_tgt;
    end
  end

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter and IF/ID register with a three-state fetch
//               FSM (INIT -> RUN -> HALT). Optional address checking is
//               enabled by defining FETCH_ADDR_CHECK_EN.
//   CLK, Reset (async, active low)
//   PCinit    [31:0] start address, loaded in INIT
//   IDataOut  [31:0] instruction memory read data for IAddr
//   Stall            hold PC and IF/ID
//   Branch, Zero, Jump, JumpReg, RegData   redirect control for IF/ID
//   IAddr     [31:0] current PC
//   Instr, InstrPC4, InstrValid             IF/ID register
//   Halted, FetchCount, AddrErr             status
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int         MEM_BYTES   = 10000,
  parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] PCinit,
  input  logic [31:0] IDataOut,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] RegData,
  output logic [31:0] IAddr,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC4,
  output logic        InstrValid,
  output logic        Halted,
  output logic [31:0] FetchCount,
  output logic        AddrErr
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc4_q, instr_pc4_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  fetch_count_q, fetch_count_d;

  logic         w_redirect;
  logic [31:0]  w_target_raw;
  logic [31:0]  w_target;
  logic         w_halt_hit;
  logic [31:0]  w_pc_plus4;

  logic [31:0]  pc_cand;
  logic         pc_load;

  pc_next_sel u_pc_next_sel (
    .i_instr_idx   (instr_q[JIDX_MSB:0]),
    .i_instr_pc4   (instr_pc4_q),
    .i_instr_valid (instr_valid_q),
    .i_branch      (Branch),
    .i_zero        (Zero),
    .i_jump        (Jump),
    .i_jump_reg    (JumpReg),
    .i_reg_data    (RegData),
    .o_redirect    (w_redirect),
    .o_target      (w_target_raw)
  );

  assign w_halt_hit = instr_valid_q & is_halt_op(instr_q, HALT_OPCODE);
  assign w_pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_ADDR_CHECK_EN
  // Misaligned targets are caught by the check rather than silently masked.
  localparam logic [31:0] c_last_addr = 32'(MEM_BYTES - 4);

  logic addr_err_q, addr_err_d;
  logic w_pc_bad;

  assign w_target = w_target_raw;
  assign w_pc_bad = (pc_cand[1:0] != 2'b00) || (pc_cand > c_last_addr);
  assign AddrErr  = addr_err_q;
`else
  assign w_target = {w_target_raw[31:2], 2'b00};
  assign AddrErr  = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc4_d   = instr_pc4_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;
    pc_cand       = pc_q;
    pc_load       = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        pc_cand       = PCinit;
        pc_load       = 1'b1;
        instr_d       = NOP_WORD;
        instr_valid_d = 1'b0;
        state_d       = ST_RUN;
      end
      ST_RUN: begin
        if (w_halt_hit) begin
          state_d       = ST_HALT;
          instr_d       = NOP_WORD;
          instr_valid_d = 1'b0;
        end else if (w_redirect) begin
          // Redirect wins over Stall: the wrong-path fetch is squashed.
          pc_cand       = w_target;
          pc_load       = 1'b1;
          instr_d       = NOP_WORD;
          instr_valid_d = 1'b0;
        end else if (!Stall) begin
          pc_cand       = w_pc_plus4;
          pc_load       = 1'b1;
          instr_d       = IDataOut;
          instr_pc4_d   = w_pc_plus4;
          instr_valid_d = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      ST_HALT: begin
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (pc_load) begin
      pc_d = pc_cand;
    end
  end

`ifdef FETCH_ADDR_CHECK_EN
  // A bad next PC stops fetch with the last good PC preserved.
  always_comb begin
    addr_err_d = addr_err_q;
    if (pc_load && w_pc_bad) begin
      addr_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q       <= ST_INIT;
      pc_q          <= 32'h0;
      instr_q       <= NOP_WORD;
      instr_pc4_q   <= 32'h0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= 32'h0;
`ifdef FETCH_ADDR_CHECK_EN
    end else if (pc_load && w_pc_bad) begin
      state_q       <= ST_HALT;
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc4_q   <= instr_pc4_d;
      instr_valid_q <= instr_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign IAddr      = pc_q;
  assign Instr      = instr_q;
  assign InstrPC4   = instr_pc4_q;
  assign InstrValid = instr_valid_q;
  assign Halted     = (state_q == ST_HALT);
  assign FetchCount = fetch_count_q;

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for pc_fetch_unit. A behavioural
//               model computes each edge's expected state, which is queued
//               and compared once the DUT has taken the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] PCinit;
  logic [31:0] IDataOut;
  logic        Stall, Branch, Zero, Jump, JumpReg;
  logic [31:0] RegData;
  logic [31:0] IAddr, Instr, InstrPC4, FetchCount;
  logic        InstrValid, Halted, AddrErr;

  logic [31:0] mem [0:63];
  assign IDataOut = mem[IAddr[7:2]];

  always #5 CLK = ~CLK;

  pc_fetch_unit dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .PCinit     (PCinit),
    .IDataOut   (IDataOut),
    .Stall      (Stall),
    .Branch     (Branch),
    .Zero       (Zero),
    .Jump       (Jump),
    .JumpReg    (JumpReg),
    .RegData    (RegData),
    .IAddr      (IAddr),
    .Instr      (Instr),
    .InstrPC4   (InstrPC4),
    .InstrValid (InstrValid),
    .Halted     (Halted),
    .FetchCount (FetchCount),
    .AddrErr    (AddrErr)
  );

  typedef struct {
    logic [31:0] pc, instr, pc4, cnt;
    logic        valid, halted, aerr;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Model state: 0 INIT, 1 RUN, 2 HALT
  int          m_state;
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_aerr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_cnt = 0;
    m_valid = 0; m_aerr = 0;
  endtask

  // Applies a candidate PC to the model, honouring the optional check.
  task automatic model_load_pc(input logic [31:0] np);
`ifdef FETCH_ADDR_CHECK_EN
    if (np[1:0] != 2'b00 || np > 32'd9996) begin
      m_aerr = 1; m_state = 2; m_instr = 0; m_valid = 0;
      return;
    end
`endif
    m_pc = np;
  endtask

  task automatic step(input logic st, input logic br, input logic zr,
                      input logic jp, input logic jrg, input logic [31:0] rd);
    exp_t e, got;
    logic [31:0] tgt, fetched;
    logic [31:0] old_cnt, old_pc;
    Stall = st; Branch = br; Zero = zr; Jump = jp; JumpReg = jrg; RegData = rd;
    case (m_state)
      0: begin
        m_instr = 0; m_valid = 0; m_state = 1;
        model_load_pc(PCinit);
      end
      1: begin
        if (m_valid && m_instr[31:26] == 6'h3f) begin
          m_state = 2; m_instr = 0; m_valid = 0;
        end else if (m_valid && (jrg || jp || (br && zr))) begin
          if (jrg)     tgt = rd;
          else if (jp) tgt = {m_pc4[31:28], m_instr[25:0], 2'b00};
          else         tgt = m_pc4 + {{14{m_instr[15]}}, m_instr[15:0], 2'b00};
`ifndef FETCH_ADDR_CHECK_EN
          tgt[1:0] = 2'b00;
`endif
          m_instr = 0; m_valid = 0;
          model_load_pc(tgt);
        end else if (!st) begin
          fetched = mem[m_pc[7:2]];
          old_cnt = m_cnt; old_pc = m_pc;
          model_load_pc(m_pc + 32'd4);
          if (m_state == 1) begin
            m_instr = fetched; m_pc4 = old_pc + 32'd4; m_valid = 1;
            m_cnt = old_cnt + 32'd1;
          end
        end
      end
      default: m_valid = 0;
    endcase
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.cnt = m_cnt;
    e.valid = m_valid; e.halted = (m_state == 2); e.aerr = m_aerr;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    got = sb.pop_front();
    chk("IAddr",      IAddr,               got.pc);
    chk("Instr",      Instr,               got.instr);
    chk("InstrPC4",   InstrPC4,            got.pc4);
    chk("InstrValid", {31'b0, InstrValid}, {31'b0, got.valid});
    chk("Halted",     {31'b0, Halted},     {31'b0, got.halted});
    chk("FetchCount", FetchCount,          got.cnt);
    chk("AddrErr",    {31'b0, AddrErr},    {31'b0, got.aerr});
  endtask

  task automatic check_reset_state();
    chk("rst_IAddr",      IAddr,               32'h0);
    chk("rst_Instr",      Instr,               32'h0);
    chk("rst_InstrPC4",   InstrPC4,            32'h0);
    chk("rst_InstrValid", {31'b0, InstrValid}, 32'h0);
    chk("rst_Halted",     {31'b0, Halted},     32'h0);
    chk("rst_FetchCount", FetchCount,          32'h0);
    chk("rst_AddrErr",    {31'b0, AddrErr},    32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'h4001_0016;   // ori
    mem[1]  = 32'h2002_0005;   // addi
    mem[2]  = 32'h0022_1820;   // add
    mem[5]  = 32'h1000_0005;   // beq imm=5 at 0x14
    mem[9]  = 32'hFC00_0000;   // halt at 0x24
    mem[11] = 32'h0800_0004;   // j index 4 at 0x2C

    Reset = 1'b0; PCinit = 32'h0;
    Stall = 0; Branch = 0; Zero = 0; Jump = 0; JumpReg = 0; RegData = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_reset_state();

    @(negedge CLK) Reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);               // INIT: PC <= PCinit
    chk("init_IAddr", IAddr, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("seq1_Instr", Instr, 32'h4001_0016);
    chk("seq1_IAddr", IAddr, 32'h4);
    chk("seq1_Count", FetchCount, 32'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("seq2_IAddr", IAddr, 32'h8);

    repeat (3) step(1, 0, 0, 0, 0, 0);   // stall at 0x8
    chk("stall_IAddr", IAddr, 32'h8);
    chk("stall_Instr", Instr, 32'h2002_0005);
    chk("stall_Count", FetchCount, 32'd2);

    repeat (4) step(0, 0, 0, 0, 0, 0);   // fetch through 0x14
    chk("beq_in_IFID", Instr, 32'h1000_0005);
    step(0, 1, 1, 0, 0, 0);               // taken branch
    chk("br_IAddr", IAddr, 32'h2C);
    chk("br_Instr", Instr, 32'h0);
    chk("br_Count", FetchCount, 32'd6);

    step(0, 0, 0, 0, 0, 0);               // fetch j at 0x2C
    step(1, 0, 0, 1, 0, 0);               // jump while stalled
    chk("j_IAddr", IAddr, 32'h10);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h20);          // jr beats j
    chk("jr_IAddr", IAddr, 32'h20);

    step(0, 1, 0, 0, 0, 0);               // branch not taken
    chk("bnt_IAddr", IAddr, 32'h24);
    step(0, 0, 0, 0, 1, 32'h22);          // misaligned jr target
`ifdef FETCH_ADDR_CHECK_EN
    chk("jr22_AddrErr", {31'b0, AddrErr}, 32'h1);
    chk("jr22_Halted",  {31'b0, Halted},  32'h1);
`else
    chk("jr22_IAddr",   IAddr, 32'h20);
    chk("jr22_AddrErr", {31'b0, AddrErr}, 32'h0);
`endif

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);               // halt word enters IF/ID
    step(0, 0, 0, 0, 0, 0);               // halt detected
    step(1, 1, 1, 1, 1, 32'h40);          // inputs ignored in HALT
    step(0, 0, 0, 0, 0, 0);

    // Asynchronous reset pulse mid-cycle, restart from a new PCinit.
    Reset = 1'b0; PCinit = 32'h8;
    #2;
    check_reset_state();
    model_reset();
    @(negedge CLK) Reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    chk("restart_IAddr", IAddr, 32'h8);
    step(0, 0, 0, 0, 0, 0);
    chk("restart_Instr", Instr, 32'h0022_1820);
    chk("restart_Count", FetchCount, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pc_fetch_unit
`default_nettype wire
